// File: rtl/ps_avalon_tx_ari_bridge_if.sv
// Stream bundle between the SGDMA TX Avalon-ST source and the MTL ARI sink.
// The slave modport is the bridge's view; the master modport is the environment's.
interface ps_avalon_tx_ari_bridge_if #(
  parameter int DATA_W = 32
);
  localparam int BYTES   = DATA_W / 8;
  localparam int EMPTY_W = $clog2(BYTES);

  // Avalon-ST side
  logic [DATA_W-1:0]  st_data;
  logic               st_valid;
  logic               st_ready;
  logic               st_sop;
  logic               st_eop;
  logic [EMPTY_W-1:0] st_empty;

  // MTL ARI side
  logic               ari_val;
  logic               ari_sof;
  logic               ari_eof;
  logic [BYTES-1:0]   ari_be;
  logic [DATA_W-1:0]  ari_data;
  logic               ari_ack;

  modport slave (
    input  st_data, st_valid, st_sop, st_eop, st_empty, ari_ack,
    output st_ready, ari_val, ari_sof, ari_eof, ari_be, ari_data
  );

  modport master (
    output st_data, st_valid, st_sop, st_eop, st_empty, ari_ack,
    input  st_ready, ari_val, ari_sof, ari_eof, ari_be, ari_data
  );
endinterface

// File: rtl/ps_avalon_tx_ari_bridge.sv
// Avalon-ST (SGDMA TX) to GMAC MTL ARI bridge: strips the length header beat,
// forwards payload through one output register and checks payload length.
module ps_avalon_tx_ari_bridge #(
  parameter int DATA_W = 32,
  parameter int LEN_W  = 15,
  parameter int CNT_W  = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  ps_avalon_tx_ari_bridge_if.slave bus,
  output logic [LEN_W-1:0]         o_ari_frame_len,
  output logic                     o_ari_frame_len_val,
  output logic                     o_len_err,
  output logic [CNT_W-1:0]         o_err_cnt,
  output logic [CNT_W-1:0]         o_drop_cnt
);
  localparam int BYTES   = DATA_W / 8;
  localparam int EMPTY_W = $clog2(BYTES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SOF  = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  state_t state_reg, state_next;

  logic               ari_val_reg;
  logic               ari_sof_reg;
  logic               ari_eof_reg;
  logic [BYTES-1:0]   ari_be_reg;
  logic [DATA_W-1:0]  ari_data_reg;
  logic [LEN_W-1:0]   frame_len_reg;
  logic               frame_len_val_reg;
  logic [LEN_W:0]     byte_cnt_reg;
  logic               len_err_reg;
  logic [CNT_W-1:0]   err_cnt_reg;
  logic [CNT_W-1:0]   drop_cnt_reg;

  logic               ld;
  logic               st_ready;
  logic               accept;
  logic               hdr_acc;
  logic               hdr_only;
  logic               drop_acc;
  logic               pay_acc;
  logic [EMPTY_W-1:0] empty_clamped;
  logic [EMPTY_W:0]   last_bytes;
  logic [EMPTY_W:0]   beat_bytes;
  logic [BYTES-1:0]   be_eop;
  logic [LEN_W+1:0]   cnt_sum;
  logic [LEN_W:0]     cnt_sat;
  logic               len_mismatch;
  logic               err_evt;

  // Output register may take a new beat when empty or when its beat leaves now.
  assign ld       = ~ari_val_reg | bus.ari_ack;
  assign st_ready = ~i_rst & ((state_reg == ST_IDLE) | ld);
  assign accept   = bus.st_valid & st_ready;

  assign hdr_acc  = accept & (state_reg == ST_IDLE) &  bus.st_sop & ~bus.st_eop;
  assign hdr_only = accept & (state_reg == ST_IDLE) &  bus.st_sop &  bus.st_eop;
  assign drop_acc = accept & (state_reg == ST_IDLE) & ~bus.st_sop;
  assign pay_acc  = accept & (state_reg != ST_IDLE);

  // Compare one bit wider so BYTES == 2**EMPTY_W does not wrap to zero.
  assign empty_clamped = ({1'b0, bus.st_empty} >= (EMPTY_W+1)'(BYTES))
                         ? EMPTY_W'(BYTES - 1) : bus.st_empty;
  assign last_bytes    = (EMPTY_W+1)'(BYTES) - {1'b0, empty_clamped};
  assign beat_bytes    = bus.st_eop ? last_bytes : (EMPTY_W+1)'(BYTES);

  generate
    for (genvar gi = 0; gi < BYTES; gi++) begin : g_be
      assign be_eop[gi] = ((EMPTY_W+1)'(gi) < last_bytes);
    end
  endgenerate

  assign cnt_sum      = {1'b0, byte_cnt_reg} + {{(LEN_W+1-EMPTY_W){1'b0}}, beat_bytes};
  assign cnt_sat      = cnt_sum[LEN_W+1] ? {(LEN_W+1){1'b1}} : cnt_sum[LEN_W:0];
  assign len_mismatch = (cnt_sat != {1'b0, frame_len_reg});
  assign err_evt      = hdr_only
                      | (pay_acc & bus.st_sop)
                      | (pay_acc & bus.st_eop & len_mismatch);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (hdr_acc) state_next = ST_SOF;
      ST_SOF:  if (pay_acc) state_next = bus.st_eop ? ST_IDLE : ST_DATA;
      ST_DATA: if (pay_acc && bus.st_eop) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ari_val_reg       <= 1'b0;
      ari_sof_reg       <= 1'b0;
      ari_eof_reg       <= 1'b0;
      ari_be_reg        <= '0;
      ari_data_reg      <= '0;
      frame_len_reg     <= '0;
      frame_len_val_reg <= 1'b0;
      byte_cnt_reg      <= '0;
      len_err_reg       <= 1'b0;
      err_cnt_reg       <= '0;
      drop_cnt_reg      <= '0;
    end else begin
      if (ld) begin
        ari_val_reg <= pay_acc;
        if (pay_acc) begin
          ari_data_reg <= bus.st_data;
          ari_sof_reg  <= (state_reg == ST_SOF);
          ari_eof_reg  <= bus.st_eop;
          ari_be_reg   <= bus.st_eop ? be_eop : {BYTES{1'b1}};
        end
      end

      // A new header wins over the SOF completion of the previous frame.
      if (hdr_acc) begin
        frame_len_reg     <= bus.st_data[LEN_W-1:0];
        frame_len_val_reg <= 1'b1;
        byte_cnt_reg      <= '0;
      end else begin
        if (ari_val_reg && bus.ari_ack && ari_sof_reg) begin
          frame_len_val_reg <= 1'b0;
        end
        if (pay_acc) begin
          byte_cnt_reg <= cnt_sat;
        end
      end

      len_err_reg <= err_evt;
      if (err_evt && !(&err_cnt_reg)) begin
        err_cnt_reg <= err_cnt_reg + CNT_W'(1);
      end
      if (drop_acc && !(&drop_cnt_reg)) begin
        drop_cnt_reg <= drop_cnt_reg + CNT_W'(1);
      end
    end
  end

  assign bus.st_ready        = st_ready;
  assign bus.ari_val         = ari_val_reg;
  assign bus.ari_sof         = ari_sof_reg;
  assign bus.ari_eof         = ari_eof_reg;
  assign bus.ari_be          = ari_be_reg;
  assign bus.ari_data        = ari_data_reg;
  assign o_ari_frame_len     = frame_len_reg;
  assign o_ari_frame_len_val = frame_len_val_reg;
  assign o_len_err           = len_err_reg;
  assign o_err_cnt           = err_cnt_reg;
  assign o_drop_cnt          = drop_cnt_reg;
endmodule

// File: tb/tb_ps_avalon_tx_ari_bridge.sv
// Directed bench for ps_avalon_tx_ari_bridge: a 32-bit and a 64-bit instance
// driven with hand-built frames; ARI beats are collected and compared.
module tb_ps_avalon_tx_ari_bridge;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ps_avalon_tx_ari_bridge_if #(.DATA_W(32)) bus32 ();
  ps_avalon_tx_ari_bridge_if #(.DATA_W(64)) bus64 ();

  logic [14:0] flen32, flen64;
  logic        flv32, flv64, lerr32, lerr64;
  logic [15:0] ecnt32, ecnt64, dcnt32, dcnt64;

  ps_avalon_tx_ari_bridge #(.DATA_W(32), .LEN_W(15), .CNT_W(16)) dut32 (
    .i_clk(clk), .i_rst(rst), .bus(bus32),
    .o_ari_frame_len(flen32), .o_ari_frame_len_val(flv32), .o_len_err(lerr32),
    .o_err_cnt(ecnt32), .o_drop_cnt(dcnt32)
  );

  ps_avalon_tx_ari_bridge #(.DATA_W(64), .LEN_W(15), .CNT_W(16)) dut64 (
    .i_clk(clk), .i_rst(rst), .bus(bus64),
    .o_ari_frame_len(flen64), .o_ari_frame_len_val(flv64), .o_len_err(lerr64),
    .o_err_cnt(ecnt64), .o_drop_cnt(dcnt64)
  );

  typedef struct {
    logic [63:0] data;
    logic        sof;
    logic        eof;
    logic [7:0]  be;
    logic        err;
    int          cyc;
  } beat_t;

  beat_t q32[$];
  beat_t q64[$];
  beat_t b32, b64;
  int cyc = 0;
  int total = 0;
  int bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Completed ARI beats, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst && bus32.ari_val && bus32.ari_ack) begin
      b32.data = 64'(bus32.ari_data); b32.sof = bus32.ari_sof; b32.eof = bus32.ari_eof;
      b32.be = 8'(bus32.ari_be); b32.err = lerr32; b32.cyc = cyc;
      q32.push_back(b32);
    end
    if (!rst && bus64.ari_val && bus64.ari_ack) begin
      b64.data = bus64.ari_data; b64.sof = bus64.ari_sof; b64.eof = bus64.ari_eof;
      b64.be = bus64.ari_be; b64.err = lerr64; b64.cyc = cyc;
      q64.push_back(b64);
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic push32(input logic [31:0] d, input logic s, input logic e, input logic [1:0] em);
    int n = 0;
    bus32.st_data = d; bus32.st_sop = s; bus32.st_eop = e; bus32.st_empty = em;
    bus32.st_valid = 1'b1;
    @(negedge clk);
    while (!bus32.st_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("push32_ready_timeout", 64'(bus32.st_ready), 1);
    @(posedge clk); #1;
    bus32.st_valid = 1'b0;
  endtask

  task automatic push64(input logic [63:0] d, input logic s, input logic e, input logic [2:0] em);
    int n = 0;
    bus64.st_data = d; bus64.st_sop = s; bus64.st_eop = e; bus64.st_empty = em;
    bus64.st_valid = 1'b1;
    @(negedge clk);
    while (!bus64.st_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("push64_ready_timeout", 64'(bus64.st_ready), 1);
    @(posedge clk); #1;
    bus64.st_valid = 1'b0;
  endtask

  task automatic drain();
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus32.st_valid = 0; bus32.st_data = '0; bus32.st_sop = 0; bus32.st_eop = 0; bus32.st_empty = '0;
    bus64.st_valid = 0; bus64.st_data = '0; bus64.st_sop = 0; bus64.st_eop = 0; bus64.st_empty = '0;
    bus32.ari_ack = 1'b1;
    bus64.ari_ack = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_val", bus32.ari_val, 0);
    check("rst_ready", bus32.st_ready, 0);
    check("rst_flen_val", flv32, 0);
    check("rst_err_cnt", ecnt32, 0);
    check("rst_drop_cnt", dcnt32, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("idle_ready", bus32.st_ready, 1);

    // Frame of 10 bytes: 4 + 4 + 2
    push32(32'h0000_000A, 1, 0, 0);
    check("t1_flen_val", flv32, 1);
    check("t1_flen", flen32, 10);
    push32(32'h1111_1111, 0, 0, 0);
    check("t1_lat_val", bus32.ari_val, 1);
    check("t1_lat_data", bus32.ari_data, 32'h1111_1111);
    push32(32'h2222_2222, 0, 0, 0);
    push32(32'h3333_3333, 0, 1, 2);
    drain();
    check("t1_nbeats", q32.size(), 3);
    if (q32.size() == 3) begin
      check("t1_b0_sof", q32[0].sof, 1);
      check("t1_b0_eof", q32[0].eof, 0);
      check("t1_b0_be", q32[0].be, 8'hF);
      check("t1_b2_sof", q32[2].sof, 0);
      check("t1_b2_eof", q32[2].eof, 1);
      check("t1_b2_be", q32[2].be, 8'h3);
      check("t1_b2_data", q32[2].data, 64'h3333_3333);
      check("t1_b2_err", q32[2].err, 0);
    end
    check("t1_flen_val_drop", flv32, 0);
    check("t1_err_cnt", ecnt32, 0);
    q32.delete();

    // Same frame, ARI stalls for 5 cycles on beat 2
    fork
      begin
        push32(32'h0000_000A, 1, 0, 0);
        push32(32'h1111_1111, 0, 0, 0);
        push32(32'h2222_2222, 0, 0, 0);
        push32(32'h3333_3333, 0, 1, 2);
      end
      begin : stall_thr
        int n;
        n = 0;
        while (!(bus32.ari_val && bus32.ari_data == 32'h2222_2222) && n < 50) begin
          @(posedge clk); #1;
          n++;
        end
        check("t2_seen_b2", bus32.ari_data, 32'h2222_2222);
        bus32.ari_ack = 1'b0;
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          check("t2_hold_ready", bus32.st_ready, 0);
          check("t2_hold_val", bus32.ari_val, 1);
          check("t2_hold_data", bus32.ari_data, 32'h2222_2222);
        end
        @(posedge clk); #1;
        bus32.ari_ack = 1'b1;
      end
    join
    drain();
    check("t2_nbeats", q32.size(), 3);
    if (q32.size() == 3) begin
      check("t2_b0_data", q32[0].data, 64'h1111_1111);
      check("t2_b1_data", q32[1].data, 64'h2222_2222);
      check("t2_b2_data", q32[2].data, 64'h3333_3333);
    end
    check("t2_err_cnt", ecnt32, 0);
    q32.delete();

    // Header 12 but only 8 payload bytes
    push32(32'h0000_000C, 1, 0, 0);
    push32(32'hAAAA_0001, 0, 0, 0);
    push32(32'hAAAA_0002, 0, 1, 0);
    drain();
    check("t3_nbeats", q32.size(), 2);
    if (q32.size() == 2) begin
      check("t3_b0_err", q32[0].err, 0);
      check("t3_b1_err", q32[1].err, 1);
      check("t3_b1_eof", q32[1].eof, 1);
      check("t3_b1_data", q32[1].data, 64'hAAAA_0002);
    end
    check("t3_err_cnt", ecnt32, 1);
    q32.delete();

    // Two beats without SOP in IDLE, then a good 4-byte frame
    push32(32'hBAD0_0001, 0, 0, 0);
    push32(32'hBAD0_0002, 0, 1, 0);
    check("t4_drop_cnt", dcnt32, 2);
    push32(32'h0000_0004, 1, 0, 0);
    push32(32'hDEAD_BEEF, 0, 1, 0);
    drain();
    check("t4_nbeats", q32.size(), 1);
    if (q32.size() == 1) begin
      check("t4_b0_data", q32[0].data, 64'hDEAD_BEEF);
      check("t4_b0_sof", q32[0].sof, 1);
      check("t4_b0_eof", q32[0].eof, 1);
      check("t4_b0_be", q32[0].be, 8'hF);
    end
    check("t4_err_cnt", ecnt32, 1);
    q32.delete();

    // Header-only packet
    push32(32'h0000_0008, 1, 1, 0);
    drain();
    check("hdr_only_err_cnt", ecnt32, 2);
    check("hdr_only_nbeats", q32.size(), 0);
    check("hdr_only_flen", flen32, 4);

    // frame_len 0 with a 1-byte payload
    push32(32'h0000_0000, 1, 0, 0);
    push32(32'h0000_0077, 0, 1, 3);
    drain();
    check("flen0_err_cnt", ecnt32, 3);
    if (q32.size() == 1) begin
      check("flen0_be", q32[0].be, 8'h1);
      check("flen0_err", q32[0].err, 1);
    end else begin
      check("flen0_nbeats", q32.size(), 1);
    end
    q32.delete();

    // SOP inside a frame: forwarded as payload, flagged
    push32(32'h0000_0008, 1, 0, 0);
    push32(32'h0000_0081, 0, 0, 0);
    push32(32'h0000_0082, 1, 1, 0);
    drain();
    check("sop_in_data_nbeats", q32.size(), 2);
    if (q32.size() == 2) begin
      check("sop_in_data_sof", q32[1].sof, 0);
      check("sop_in_data_err", q32[1].err, 1);
    end
    check("sop_in_data_err_cnt", ecnt32, 4);
    q32.delete();

    // Reset mid-DATA with a beat held in the output register
    push32(32'h0000_0010, 1, 0, 0);
    push32(32'h0000_0055, 0, 0, 0);
    check("t5_pre_val", bus32.ari_val, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("t5_val", bus32.ari_val, 0);
    check("t5_sof", bus32.ari_sof, 0);
    check("t5_eof", bus32.ari_eof, 0);
    check("t5_be", bus32.ari_be, 0);
    check("t5_data", bus32.ari_data, 0);
    check("t5_ready", bus32.st_ready, 0);
    check("t5_flen", flen32, 0);
    check("t5_flen_val", flv32, 0);
    check("t5_len_err", lerr32, 0);
    check("t5_err_cnt", ecnt32, 0);
    check("t5_drop_cnt", dcnt32, 0);
    rst = 1'b0;
    q32.delete();
    push32(32'h0000_0004, 1, 0, 0);
    check("t5_new_flen", flen32, 4);
    push32(32'h0000_0066, 0, 1, 0);
    drain();
    check("t5_nbeats", q32.size(), 1);
    if (q32.size() == 1) begin
      check("t5_b0_sof", q32[0].sof, 1);
      check("t5_b0_eof", q32[0].eof, 1);
    end
    check("t5_err_cnt_after", ecnt32, 0);
    check("t5_drop_cnt_after", dcnt32, 0);
    q32.delete();

    // 64-bit: 13-byte frame then a 16-byte frame, back to back
    push64(64'h0000_0000_0000_000D, 1, 0, 0);
    push64(64'h0102_0304_0506_0708, 0, 0, 0);
    push64(64'h1112_1314_1516_1718, 0, 1, 3);
    push64(64'h0000_0000_0000_0010, 1, 0, 0);
    push64(64'h2122_2324_2526_2728, 0, 0, 0);
    push64(64'h3132_3334_3536_3738, 0, 1, 0);
    drain();
    check("t6_nbeats", q64.size(), 4);
    if (q64.size() == 4) begin
      check("t6_a1_be", q64[1].be, 8'h1F);
      check("t6_a1_eof", q64[1].eof, 1);
      check("t6_a1_err", q64[1].err, 0);
      check("t6_b0_sof", q64[2].sof, 1);
      check("t6_b1_be", q64[3].be, 8'hFF);
      check("t6_gap_a", q64[1].cyc - q64[0].cyc, 1);
      check("t6_gap_hdr", q64[2].cyc - q64[1].cyc, 2);
      check("t6_gap_b", q64[3].cyc - q64[2].cyc, 1);
    end
    check("t6_err_cnt", ecnt64, 0);
    check("t6_flen", flen64, 16);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
